// File: rtl/ctrl_pkg.sv
// Shared constants for the control sequencer: opcodes, ALU op codes,
// instruction field offsets and the sequencer state type.
package ctrl_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LI   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;
    localparam logic [1:0] ALU_NOP  = 2'b11;

    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 6;
    localparam int unsigned RS1_BIT = 5;
    localparam int unsigned RS2_BIT = 4;
    localparam int unsigned IMM_MSB = 3;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT,
        PAUSE
    } state_t;

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Combinational instruction decoder: splits an 8-bit word into register
// selects, zero-extended immediate, ALU op, write-back source and halt flag.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [7:0] instr,
    output logic       rs1,
    output logic       rs2,
    output logic [7:0] imm,
    output logic [1:0] aluOp,
    output logic       wbSel,
    output logic       isHalt
);

    logic [1:0] opcode;

    always_comb begin
        opcode = instr[OPC_MSB:OPC_LSB];
        rs1    = instr[RS1_BIT];
        rs2    = instr[RS2_BIT];
        imm    = {4'b0000, instr[IMM_MSB:IMM_LSB]};
        aluOp  = ALU_NOP;
        wbSel  = 1'b0;
        isHalt = 1'b0;
        case (opcode)
            OP_ADD:  aluOp = ALU_ADD;
            OP_SUB:  aluOp = ALU_SUB;
            OP_LI: begin
                aluOp = ALU_PASS;
                wbSel = 1'b1;
            end
            default: isHalt = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Four-phase fetch/decode/execute/writeback sequencer driving a 2-entry register file.
// Optional single-step mode (input step_go, PAUSE state) under `CTRL_STEP_EN.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned          PC_W     = 4,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [7:0]      instr_data,
    output logic            instr_ready,
    output logic [PC_W-1:0] pc,
    output logic            read_reg1,
    output logic            read_reg2,
    output logic            reg_write,
    output logic [1:0]      alu_op,
    output logic            wb_sel,
    output logic [7:0]      imm,
    output logic            halted
`ifdef CTRL_STEP_EN
    ,
    input  logic            step_go
`endif
);

    state_t     state;
    state_t     nextState;
    logic [7:0] instrReg;
    logic       accept;

    logic       decRs1;
    logic       decRs2;
    logic [7:0] decImm;
    logic [1:0] decAluOp;
    logic       decWbSel;
    logic       decIsHalt;

    instr_decode uDecode (
        .instr  (instrReg),
        .rs1    (decRs1),
        .rs2    (decRs2),
        .imm    (decImm),
        .aluOp  (decAluOp),
        .wbSel  (decWbSel),
        .isHalt (decIsHalt)
    );

    always_comb begin
        accept    = (state == FETCH) && instr_valid && instr_ready;
        nextState = state;
        case (state)
            FETCH:     if (accept) nextState = DECODE;
            DECODE:    nextState = decIsHalt ? HALT : EXECUTE;
            EXECUTE:   nextState = WRITEBACK;
`ifdef CTRL_STEP_EN
            WRITEBACK: nextState = PAUSE;
            PAUSE:     if (step_go) nextState = FETCH;
`else
            WRITEBACK: nextState = FETCH;
`endif
            HALT:      nextState = HALT;
            default:   nextState = FETCH;
        endcase
    end

    // Status outputs are registered from the next state so each one lines up
    // exactly with the cycle the FSM spends in the corresponding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instrReg    <= '0;
            instr_ready <= 1'b0;
            read_reg1   <= 1'b0;
            read_reg2   <= 1'b0;
            reg_write   <= 1'b0;
            alu_op      <= ALU_NOP;
            wb_sel      <= 1'b0;
            imm         <= '0;
            halted      <= 1'b0;
        end else begin
            state       <= nextState;
            instr_ready <= (nextState == FETCH);
            reg_write   <= (nextState == WRITEBACK);
            halted      <= (nextState == HALT);
            if (accept) begin
                instrReg <= instr_data;
                pc       <= pc + PC_W'(1);
            end
            if (state == DECODE) begin
                read_reg1 <= decRs1;
                read_reg2 <= decRs2;
                imm       <= decImm;
                alu_op    <= decAluOp;
                wb_sel    <= decWbSel;
            end
            if (nextState == HALT) alu_op <= ALU_NOP;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed and random instruction
// streams checked against an instruction-level reference model.
module tb_control_sequencer;

    localparam int unsigned PC_W = 4;
    localparam int unsigned PC_MOD = 1 << PC_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            instr_valid = 1'b0;
    logic [7:0]      instr_data = '0;
    logic            instr_ready;
    logic [PC_W-1:0] pc;
    logic            read_reg1;
    logic            read_reg2;
    logic            reg_write;
    logic [1:0]      alu_op;
    logic            wb_sel;
    logic [7:0]      imm;
    logic            halted;
`ifdef CTRL_STEP_EN
    logic            step_go = 1'b0;
`endif

    control_sequencer #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .pc          (pc),
        .read_reg1   (read_reg1),
        .read_reg2   (read_reg2),
        .reg_write   (reg_write),
        .alu_op      (alu_op),
        .wb_sel      (wb_sel),
        .imm         (imm),
        .halted      (halted)
`ifdef CTRL_STEP_EN
        ,
        .step_go     (step_go)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register file the sequencer controls; the write target is always read_reg1.
    logic [7:0] rf [2];
    int         writeCount = 0;

    always @(posedge clk) begin
        if (rst_n && reg_write) begin
            if (wb_sel) rf[read_reg1] <= imm;
            else if (alu_op == 2'b00) rf[read_reg1] <= rf[read_reg1] + rf[read_reg2];
            else if (alu_op == 2'b01) rf[read_reg1] <= rf[read_reg1] - rf[read_reg2];
            writeCount <= writeCount + 1;
        end
    end

    // Instruction-level reference model.
    logic [7:0] refRf [2];
    int         refPc = 0;

    task automatic waitReady();
        int waited = 0;
        while (instr_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkVal("ready_wait", 32'(waited < 40), 1);
    endtask

    task automatic issue(input logic [7:0] ins);
        logic [1:0] op;
        logic       rd;
        logic       rs;
        logic [7:0] newVal;
        int         startWrites;
        op = ins[7:6];
        rd = ins[5];
        rs = ins[4];
        waitReady();
        instr_valid = 1'b1;
        instr_data  = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_data  = 8'($urandom);
        startWrites = writeCount;
        refPc = (refPc + 1) % PC_MOD;

        @(negedge clk);
        checkVal("pc_after_fetch", 32'(pc), 32'(refPc));
        checkVal("we_decode", 32'(reg_write), 0);
        checkVal("ready_decode", 32'(instr_ready), 0);

        if (op == 2'b11) begin
            @(negedge clk);
            checkVal("halted", 32'(halted), 1);
            checkVal("halt_ready", 32'(instr_ready), 0);
            checkVal("halt_aluop", 32'(alu_op), 3);
            checkVal("halt_we", 32'(reg_write), 0);
            return;
        end

        @(negedge clk);
        checkVal("we_execute", 32'(reg_write), 0);
        checkVal("rs1_execute", 32'(read_reg1), 32'(rd));

        @(negedge clk);
        checkVal("we_writeback", 32'(reg_write), 1);
        checkVal("rs1_writeback", 32'(read_reg1), 32'(rd));
        checkVal("aluop", 32'(alu_op), 32'(op));
        checkVal("wbsel", 32'(wb_sel), 32'(op == 2'b10));
        if (op == 2'b10) begin
            checkVal("imm", 32'(imm), 32'(ins & 8'h0F));
            newVal = ins & 8'h0F;
        end else begin
            checkVal("rs2", 32'(read_reg2), 32'(rs));
            newVal = (op == 2'b00) ? refRf[rd] + refRf[rs] : refRf[rd] - refRf[rs];
        end
        refRf[rd] = newVal;

        @(negedge clk);
        checkVal("we_pulse_end", 32'(reg_write), 0);
        checkVal("write_count", 32'(writeCount - startWrites), 1);
        checkVal("rf_value", 32'(rf[rd]), 32'(refRf[rd]));
`ifdef CTRL_STEP_EN
        for (int i = 0; i < 3; i++) begin
            checkVal("pause_no_fetch", 32'(instr_ready), 0);
            @(negedge clk);
        end
        step_go = 1'b1;
        @(negedge clk);
        step_go = 1'b0;
        checkVal("step_resume", 32'(instr_ready), 1);
`else
        checkVal("ready_after_wb", 32'(instr_ready), 1);
`endif
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        checkVal("rst_pc", 32'(pc), 0);
        checkVal("rst_we", 32'(reg_write), 0);
        checkVal("rst_ready", 32'(instr_ready), 0);
        checkVal("rst_halted", 32'(halted), 0);
        checkVal("rst_aluop", 32'(alu_op), 3);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        refPc = 0;
        @(negedge clk);
        checkVal("ready_after_rst", 32'(instr_ready), 1);
        checkVal("pc_after_rst", 32'(pc), 0);
    endtask

    initial begin
        int startWrites;
        rf[0] = 8'h00;
        rf[1] = 8'h00;
        refRf[0] = 8'h00;
        refRf[1] = 8'h00;

        repeat (3) @(negedge clk);
        checkVal("reset_pc", 32'(pc), 0);
        checkVal("reset_we", 32'(reg_write), 0);
        checkVal("reset_ready", 32'(instr_ready), 0);
        checkVal("reset_halted", 32'(halted), 0);
        checkVal("reset_aluop", 32'(alu_op), 3);
        checkVal("reset_imm", 32'(imm), 0);
        checkVal("reset_rs1", 32'(read_reg1), 0);
        checkVal("reset_wbsel", 32'(wb_sel), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("ready_1cyc", 32'(instr_ready), 1);
        checkVal("pc_1cyc", 32'(pc), 0);

        issue(8'h82);
        issue(8'hA5);
        issue(8'h10);
        checkVal("add_r0", 32'(rf[0]), 7);

        startWrites = writeCount;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkVal("idle_pc", 32'(pc), 32'(refPc));
            checkVal("idle_we", 32'(reg_write), 0);
        end
        checkVal("idle_writes", 32'(writeCount - startWrites), 0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] ins;
            ins = {2'($urandom_range(0, 2)), 6'($urandom)};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(ins);
        end

        // Abort an ADD in EXECUTE: no write pulse may appear.
        waitReady();
        instr_valid = 1'b1;
        instr_data  = 8'h30;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        startWrites = writeCount;
        @(negedge clk);
        @(negedge clk);
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            checkVal("abort_we", 32'(reg_write), 0);
            @(negedge clk);
        end
        checkVal("abort_writes", 32'(writeCount - startWrites), 0);

        issue(8'hC0);
        startWrites = writeCount;
        instr_valid = 1'b1;
        instr_data  = 8'h85;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkVal("halt_hold_ready", 32'(instr_ready), 0);
            checkVal("halt_hold", 32'(halted), 1);
        end
        instr_valid = 1'b0;
        checkVal("halt_writes", 32'(writeCount - startWrites), 0);
        checkVal("halt_pc", 32'(pc), 32'(refPc));

        pulseReset();
        checkVal("halt_cleared", 32'(halted), 0);
        issue(8'hB9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
